mv_ctrl_fsm: RTL and testbench

Sequencer for the matrix-vector multiply datapath, and the successor to the fixed-N lab FSM.
- Issues N operand reads from BRAM at a programmable base, then waits out BRAM read latency.
- Then emits M result writes to a programmable base.
- Explicit start/busy/done handshake; BRAM read latency is a parameter.
- Drives the MAC array (init, acc_en) and the result shift register (shift_en).

---
 rtl/mv_ctrl_pkg.sv | 18 +
 rtl/mv_ctrl_fsm_valid_pipe.sv | 31 +++
 rtl/mv_ctrl_fsm.sv | 150 +++++++++++++++
 tb/tb_mv_ctrl_fsm.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mv_ctrl_pkg.sv
// Shared types and helpers for the matrix-vector multiply sequencer.
package mv_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    WRITE,
    DONE
  } state_t;

  localparam int RD_LAT_MAX = 4;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mv_ctrl_fsm_valid_pipe.sv
// Delays the {first, valid} read-beat flags by the BRAM read latency so they
// line up with read data arriving at the MAC array.
module mv_valid_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic first_i,
  input  logic valid_i,
  output logic first_o,
  output logic valid_o
);

  logic [1:0] stage_q [DEPTH];

  // NOTE: sequential state is written with <= so every stage samples its
  // neighbour's pre-edge value; blocking here would collapse the pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every stage is cleared (the array is tiny) so an aborted job
      // cannot leave a stale valid or first beat in flight.
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= {first_i, valid_i};
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign {first_o, valid_o} = stage_q[DEPTH-1];

endmodule

// File: rtl/mv_ctrl_fsm.sv
// Job sequencer: N operand reads, drain for read latency, M result writes,
// with start/busy/done handshake and MAC/shift-register controls.
module mv_ctrl_fsm
  import mv_ctrl_pkg::*;
#(
  parameter int N          = 4,
  parameter int M          = 4,
  parameter int BRAM_DEPTH = 32,
  parameter int RD_LAT     = 1,
  localparam int AW        = addr_width(BRAM_DEPTH),
  localparam int WCW       = $clog2(M + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic [AW-1:0]  rd_base_i,
  input  logic [AW-1:0]  wr_base_i,
  output logic           busy_o,
  output logic           done_o,
  output logic           rd_en_o,
  output logic [AW-1:0]  rd_addr_o,
  output logic           init_o,
  output logic           acc_en_o,
  output logic           shift_en_o,
  output logic           mem_wr_en_o,
  output logic [AW-1:0]  wr_addr_o,
  output logic [WCW-1:0] wr_count_o
);

  localparam int CW = $clog2(N + RD_LAT + 1);

  if (N < 1 || M < 1 || RD_LAT < 1 || RD_LAT > RD_LAT_MAX ||
      N >= BRAM_DEPTH || M > BRAM_DEPTH) begin : g_bad_params
    $error("mv_ctrl_fsm: illegal parameter combination");
  end

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [AW-1:0]  wr_base_q;
  logic [AW-1:0]  rd_addr_q;
  logic [AW-1:0]  wr_addr_q;
  logic [WCW-1:0] wr_count_q;
  logic           busy_q;
  logic           done_q;
  logic           rd_en_q;
  logic           shift_en_q;
  logic           mem_wr_en_q;
  logic           first_beat;

  // Addresses wrap modulo BRAM_DEPTH, which need not be a power of two.
  function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
    return (a == AW'(BRAM_DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_base_q   <= '0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      wr_count_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      shift_en_q  <= 1'b0;
      mem_wr_en_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      shift_en_q  <= 1'b0;
      mem_wr_en_q <= 1'b0;
      wr_count_q  <= '0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q   <= LOAD;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            wr_base_q <= wr_base_i;
            rd_addr_q <= rd_base_i;
            rd_en_q   <= 1'b1;
          end
        end
        LOAD: begin
          if (cnt_q == CW'(N - 1)) begin
            state_q <= DRAIN;
            cnt_q   <= '0;
          end else begin
            cnt_q     <= cnt_q + 1'b1;
            rd_en_q   <= 1'b1;
            rd_addr_q <= addr_inc(rd_addr_q);
          end
        end
        // Last read beat needs RD_LAT cycles to land plus one for the MAC register.
        DRAIN: begin
          if (cnt_q == CW'(RD_LAT)) begin
            state_q     <= WRITE;
            mem_wr_en_q <= 1'b1;
            wr_count_q  <= WCW'(1);
            wr_addr_q   <= wr_base_q;
            shift_en_q  <= (M > 1);
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WRITE: begin
          if (wr_count_q == WCW'(M)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            mem_wr_en_q <= 1'b1;
            wr_count_q  <= wr_count_q + 1'b1;
            wr_addr_q   <= addr_inc(wr_addr_q);
            shift_en_q  <= (wr_count_q + WCW'(1)) != WCW'(M);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign first_beat = rd_en_q && (state_q == LOAD) && (cnt_q == '0);

  mv_valid_pipe #(.DEPTH(RD_LAT)) u_valid_pipe (
    .clk     (clk),
    .rst     (rst),
    .first_i (first_beat),
    .valid_i (rd_en_q),
    .first_o (init_o),
    .valid_o (acc_en_o)
  );

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign rd_en_o     = rd_en_q;
  assign rd_addr_o   = rd_addr_q;
  assign shift_en_o  = shift_en_q;
  assign mem_wr_en_o = mem_wr_en_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_count_o  = wr_count_q;

endmodule

// File: tb/tb_mv_ctrl_fsm.sv
// Scoreboard bench for mv_ctrl_fsm over several N/M/RD_LAT configurations,
// each with its own random stimulus, job model and output monitor.
module tb_mv_ctrl_fsm;

  localparam int NCFG  = 4;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int CFG_N  [NCFG] = '{4, 4, 1, 4};
  localparam int CFG_M  [NCFG] = '{4, 4, 1, 2};
  localparam int CFG_RD [NCFG] = '{1, 3, 1, 4};

  typedef struct {
    int cyc;
    int addr;
    int cnt;
    bit flag;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int cfg, input int c,
                       input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cfg=%0d cycle=%0d got=%0d expected=%0d", name, cfg, c, act, exp);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int N   = CFG_N[g];
    localparam int M   = CFG_M[g];
    localparam int RD  = CFG_RD[g];
    localparam int WCW = $clog2(M + 1);

    logic           rst     = 1'b1;
    logic           start   = 1'b0;
    logic [AW-1:0]  rd_base = '0;
    logic [AW-1:0]  wr_base = '0;
    logic           busy, done, rd_en, init, acc_en, shift_en, mem_wr_en;
    logic [AW-1:0]  rd_addr, wr_addr;
    logic [WCW-1:0] wr_count;

    ev_t rdq[$], accq[$], wrq[$], doneq[$];
    int  next_ok = 0;
    int  busy_lo = 1;
    int  busy_hi = 0;
    bit  fin = 1'b0;
    bit  e_rd, e_acc, e_wr, e_dn;

    mv_ctrl_fsm #(.N(N), .M(M), .BRAM_DEPTH(DEPTH), .RD_LAT(RD)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .start_i     (start),
      .rd_base_i   (rd_base),
      .wr_base_i   (wr_base),
      .busy_o      (busy),
      .done_o      (done),
      .rd_en_o     (rd_en),
      .rd_addr_o   (rd_addr),
      .init_o      (init),
      .acc_en_o    (acc_en),
      .shift_en_o  (shift_en),
      .mem_wr_en_o (mem_wr_en),
      .wr_addr_o   (wr_addr),
      .wr_count_o  (wr_count)
    );

    // Job model: a start accepted at edge e yields reads in cycles e..e+N-1,
    // data beats RD later, writes after RD+1 drain cycles, then one done cycle.
    task automatic accept(input int e, input int rb, input int wb);
      for (int k = 0; k < N; k++) begin
        rdq.push_back('{e + k, (rb + k) % DEPTH, 0, 1'b0});
        accq.push_back('{e + k + RD, 0, 0, k == 0});
      end
      for (int j = 1; j <= M; j++)
        wrq.push_back('{e + N + RD + j, (wb + j - 1) % DEPTH, j, j < M});
      doneq.push_back('{e + N + RD + M + 1, 0, 0, 1'b0});
      busy_lo = e;
      busy_hi = e + N + RD + M + 1;
      next_ok = e + N + RD + M + 3;
    endtask

    task automatic drive(input bit s, input int rb, input int wb);
      start   = s;
      rd_base = AW'(rb);
      wr_base = AW'(wb);
      if (s && !rst && (cyc + 1 >= next_ok)) accept(cyc + 1, rb, wb);
      @(negedge clk);
    endtask

    task automatic wait_idle();
      while (cyc + 1 < next_ok) drive(1'b0, 0, 0);
    endtask

    initial begin
      int e0;
      int r;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      drive(1'b1, 0, 8);
      wait_idle();
      drive(1'b1, 30, 31);
      wait_idle();
      for (int i = 0; i < 30; i++) drive(1'b1, $urandom_range(0, 31), $urandom_range(0, 31));
      wait_idle();
      for (int i = 0; i < 300; i++)
        drive($urandom_range(0, 2) == 0, $urandom_range(0, 31), $urandom_range(0, 31));
      wait_idle();
      // Abort a job by reset in the cycle after its second write.
      e0 = cyc + 1;
      drive(1'b1, 5, 20);
      while (cyc + 1 < e0 + N + RD + 3) drive(1'b0, 0, 0);
      r     = cyc + 1;
      rst   = 1'b1;
      start = 1'b0;
      rdq.delete();
      accq.delete();
      wrq.delete();
      doneq.delete();
      if (busy_hi > r - 1) busy_hi = r - 1;
      next_ok = r + 1;
      @(negedge clk);
      rst = 1'b0;
      drive(1'b1, $urandom_range(0, 31), $urandom_range(0, 31));
      wait_idle();
      repeat (5) drive(1'b0, 0, 0);
      check("rd_left", g, cyc, rdq.size(), 0);
      check("acc_left", g, cyc, accq.size(), 0);
      check("wr_left", g, cyc, wrq.size(), 0);
      check("done_left", g, cyc, doneq.size(), 0);
      fin = 1'b1;
    end

    initial forever begin
      @(posedge clk);
      #1;
      e_rd  = rdq.size() > 0 && rdq[0].cyc == cyc;
      e_acc = accq.size() > 0 && accq[0].cyc == cyc;
      e_wr  = wrq.size() > 0 && wrq[0].cyc == cyc;
      e_dn  = doneq.size() > 0 && doneq[0].cyc == cyc;
      check("busy", g, cyc, int'(busy), int'(cyc >= busy_lo && cyc <= busy_hi));
      check("rd_en", g, cyc, int'(rd_en), int'(e_rd));
      if (e_rd && rd_en) check("rd_addr", g, cyc, int'(rd_addr), rdq[0].addr);
      check("acc_en", g, cyc, int'(acc_en), int'(e_acc));
      check("init", g, cyc, int'(init), int'(e_acc && accq[0].flag));
      check("mem_wr_en", g, cyc, int'(mem_wr_en), int'(e_wr));
      check("wr_count", g, cyc, int'(wr_count), e_wr ? wrq[0].cnt : 0);
      check("shift_en", g, cyc, int'(shift_en), int'(e_wr && wrq[0].flag));
      if (e_wr && mem_wr_en) check("wr_addr", g, cyc, int'(wr_addr), wrq[0].addr);
      check("done", g, cyc, int'(done), int'(e_dn));
      if (e_rd)  void'(rdq.pop_front());
      if (e_acc) void'(accq.pop_front());
      if (e_wr)  void'(wrq.pop_front());
      if (e_dn)  void'(doneq.pop_front());
    end
  end

  initial begin
    bit all_done;
    all_done = 1'b0;
    for (int i = 0; i < 5000 && !all_done; i++) begin
      @(negedge clk);
      all_done = g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin && g_cfg[3].fin;
    end
    check("finished_in_budget", -1, cyc, int'(all_done), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
